// File: rtl/mult_pkg.sv
// mult_pkg -- shared definitions for the shift/add multiplier.
//   state_t     : controller states (IDLE, RUN, HOLD)
//   SEG7_TABLE  : active-low seven-segment codes {g,f,e,d,c,b,a} for nibbles 0..F
//   cnt_width() : width of a step counter that must reach w-1
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [6:0] SEG7_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // At least one bit, even when the counter only needs to reach 1.
  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/addsub_nbit.sv
// addsub_nbit -- combinational ext(i_a) +/- ext(i_m) over WIDTH+1 bits.
//   i_a, i_m     : WIDTH-bit operands
//   i_signed_en  : 1 = sign-extend operands, 0 = zero-extend
//   i_sub_en     : 1 = subtract i_m, 0 = add i_m
//   o_sum        : WIDTH+1-bit result (never overflows for these extensions)
module addsub_nbit
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_m,
  input  logic             i_signed_en,
  input  logic             i_sub_en,
  output logic [WIDTH:0]   o_sum
);

  logic [WIDTH:0] w_ext_a;
  logic [WIDTH:0] w_ext_m;

  assign w_ext_a = {i_signed_en & i_a[WIDTH-1], i_a};
  assign w_ext_m = {i_signed_en & i_m[WIDTH-1], i_m};
  assign o_sum   = i_sub_en ? (w_ext_a - w_ext_m) : (w_ext_a + w_ext_m);

endmodule

// File: rtl/shift_add_multiplier_n.sv
// shift_add_multiplier_n -- sequential add/shift multiplier, one step per clock.
// The 2*WIDTH-bit product ends up in {Aval, Bval}; X is the sign bit in signed mode.
// Ports:
//   Clk, Reset    : clock, asynchronous active-high reset
//   Din           : operand switches (multiplier on ClearA_loadB, multiplicand on Execute)
//   ClearA_loadB  : in IDLE, clear A/X and load B from Din (wins over Execute)
//   Execute       : in IDLE, capture multiplicand and start a multiply
//   SignedMode    : 1 = two's-complement, 0 = unsigned; sampled at start
//   Aval, Bval, X : product registers
//   Busy          : high while stepping
//   Done          : one-cycle pulse once the product is valid
// Optional macro HEX_OUT_EN adds AhexN/BhexN active-low seven-segment decodes of
// Aval/Bval (digit 0 in bits [6:0]); WIDTH must then be a multiple of 4.
module shift_add_multiplier_n
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] Din,
  input  logic             ClearA_loadB,
  input  logic             Execute,
  input  logic             SignedMode,
  output logic [WIDTH-1:0] Aval,
  output logic [WIDTH-1:0] Bval,
  output logic             X,
  output logic             Busy,
  output logic             Done
`ifdef HEX_OUT_EN
  ,
  output logic [(WIDTH/4)*7-1:0] AhexN,
  output logic [(WIDTH/4)*7-1:0] BhexN
`endif
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  if (WIDTH < 2) begin : g_bad_width
    $error("shift_add_multiplier_n: WIDTH must be >= 2");
  end

  state_t           r_state, r_state_next;
  logic [WIDTH-1:0] r_a, r_a_next;
  logic [WIDTH-1:0] r_b, r_b_next;
  logic [WIDTH-1:0] r_m, r_m_next;
  logic             r_x, r_x_next;
  logic [CNT_W-1:0] r_cnt, r_cnt_next;
  logic             r_signed, r_signed_next;
  logic             r_done, r_done_next;

  logic             w_last;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_tmp;

  assign w_last = (r_cnt == CNT_LAST);

  // Signed mode subtracts on the final step: the multiplier's MSB carries weight -2^(WIDTH-1).
  addsub_nbit #(.WIDTH(WIDTH)) u_addsub (
    .i_a         (r_a),
    .i_m         (r_m),
    .i_signed_en (r_signed),
    .i_sub_en    (r_signed & w_last),
    .o_sum       (w_sum)
  );

  assign w_tmp = r_b[0] ? w_sum : {r_signed & r_a[WIDTH-1], r_a};

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_m      <= '0;
      r_x      <= 1'b0;
      r_cnt    <= '0;
      r_signed <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= r_state_next;
      r_a      <= r_a_next;
      r_b      <= r_b_next;
      r_m      <= r_m_next;
      r_x      <= r_x_next;
      r_cnt    <= r_cnt_next;
      r_signed <= r_signed_next;
      r_done   <= r_done_next;
    end
  end

  always_comb begin
    r_state_next  = r_state;
    r_a_next      = r_a;
    r_b_next      = r_b;
    r_m_next      = r_m;
    r_x_next      = r_x;
    r_cnt_next    = r_cnt;
    r_signed_next = r_signed;
    r_done_next   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (ClearA_loadB) begin
          r_a_next = '0;
          r_x_next = 1'b0;
          r_b_next = Din;
        end else if (Execute) begin
          r_m_next      = Din;
          r_signed_next = SignedMode;
          r_a_next      = '0;
          r_x_next      = 1'b0;
          r_cnt_next    = '0;
          r_state_next  = RUN;
        end
      end
      RUN: begin
        r_a_next   = w_tmp[WIDTH:1];
        r_b_next   = {w_tmp[0], r_b[WIDTH-1:1]};
        r_x_next   = r_signed & w_tmp[WIDTH];
        r_cnt_next = r_cnt + CNT_ONE;
        if (w_last) begin
          r_done_next  = 1'b1;
          r_state_next = HOLD;
        end
      end
      HOLD: begin
        // Execute must drop before another multiply can start.
        if (!Execute) begin
          r_state_next = IDLE;
        end
      end
      default: begin
        r_state_next = IDLE;
      end
    endcase
  end

  assign Aval = r_a;
  assign Bval = r_b;
  assign X    = r_x;
  assign Busy = (r_state == RUN);
  assign Done = r_done;

`ifdef HEX_OUT_EN
  if (WIDTH % 4 != 0) begin : g_bad_hex_width
    $error("shift_add_multiplier_n: HEX_OUT_EN needs WIDTH divisible by 4");
  end

  for (genvar gi = 0; gi < WIDTH / 4; gi++) begin : g_hex
    assign AhexN[gi*7 +: 7] = SEG7_TABLE[r_a[gi*4 +: 4]];
    assign BhexN[gi*7 +: 7] = SEG7_TABLE[r_b[gi*4 +: 4]];
  end
`else
  // No display decode in this build.
`endif

endmodule

// File: tb/tb_shift_add_multiplier_n.sv
module tb_shift_add_multiplier_n;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  logic [7:0]  din8,  a8,  b8;
  logic        ld8, ex8, sg8, x8, busy8, done8;
  logic [15:0] din16, a16, b16;
  logic        ld16, ex16, sg16, x16, busy16, done16;

  shift_add_multiplier_n #(.WIDTH(8)) u8 (
    .Clk(Clk), .Reset(Reset), .Din(din8), .ClearA_loadB(ld8), .Execute(ex8),
    .SignedMode(sg8), .Aval(a8), .Bval(b8), .X(x8), .Busy(busy8), .Done(done8)
  );

  shift_add_multiplier_n #(.WIDTH(16)) u16 (
    .Clk(Clk), .Reset(Reset), .Din(din16), .ClearA_loadB(ld16), .Execute(ex16),
    .SignedMode(sg16), .Aval(a16), .Bval(b16), .X(x16), .Busy(busy16), .Done(done16)
  );

  int n_pass = 0;
  int n_checks = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        x;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    string      nm;
    logic [7:0] b;
    logic [7:0] m;
    logic       sgn;
    logic [7:0] ea;
    logic [7:0] eb;
    logic       ex;
  } vec_t;
  vec_t vecs[10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act === expv) begin
      n_pass++;
      $display("check %s: got 0x%0h ok", nm, act);
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, expv);
    end
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic push_exp(input logic [15:0] a, input logic [15:0] b, input logic x);
    exp_t e;
    e.a = a; e.b = b; e.x = x;
    exp_q.push_back(e);
  endtask

  // Load multiplier, then accept Execute; returns 1 ns after the accept edge.
  task automatic start8(input logic [7:0] b, input logic [7:0] m, input logic sgn, input logic keep_ex);
    ld8 = 1'b1; din8 = b; ex8 = 1'b0;
    tick;
    ld8 = 1'b0; din8 = m; sg8 = sgn; ex8 = 1'b1;
    tick;
    chk("busy after accept", busy8, 1'b1);
    if (!keep_ex) ex8 = 1'b0;
    din8 = 8'($urandom);
    sg8 = ~sgn;
  endtask

  // Wait for Done (bounded), check latency, pop the scoreboard and compare.
  task automatic finish8(input string nm, input int lat);
    int c;
    exp_t e;
    c = 0;
    while (!done8 && c < 40) begin
      tick;
      c++;
    end
    chk({nm, " latency"}, 64'(c), 64'(lat));
    if (exp_q.size() == 0) begin
      chk({nm, " scoreboard"}, 64'(0), 64'(1));
    end else begin
      e = exp_q.pop_front();
      chk({nm, " A"}, a8, e.a[7:0]);
      chk({nm, " B"}, b8, e.b[7:0]);
      chk({nm, " X"}, x8, e.x);
    end
    tick;
    chk({nm, " done width"}, done8, 1'b0);
  endtask

  initial begin
    int c;
    int bad;
    int prod;
    logic [7:0] rb, rm;
    logic       rs;
    logic [15:0] p;

    vecs[0] = '{"s 0xFD*0x07", 8'hFD, 8'h07, 1'b1, 8'hFF, 8'hEB, 1'b1};
    vecs[1] = '{"u 0xFF*0xFF", 8'hFF, 8'hFF, 1'b0, 8'hFE, 8'h01, 1'b0};
    vecs[2] = '{"s 0xFF*0xFF", 8'hFF, 8'hFF, 1'b1, 8'h00, 8'h01, 1'b0};
    vecs[3] = '{"s 0x80*0x80", 8'h80, 8'h80, 1'b1, 8'h40, 8'h00, 1'b0};
    vecs[4] = '{"u 0x0D*0x0B", 8'h0D, 8'h0B, 1'b0, 8'h00, 8'h8F, 1'b0};
    vecs[5] = '{"s 0x05*0xFA", 8'h05, 8'hFA, 1'b1, 8'hFF, 8'hE2, 1'b1};
    vecs[6] = '{"s 0x7F*0x80", 8'h7F, 8'h80, 1'b1, 8'hC0, 8'h80, 1'b1};
    vecs[7] = '{"u 0x80*0x80", 8'h80, 8'h80, 1'b0, 8'h40, 8'h00, 1'b0};
    vecs[8] = '{"u 0xAB*0x00", 8'hAB, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0};
    vecs[9] = '{"s 0x80*0x7F", 8'h80, 8'h7F, 1'b1, 8'hC0, 8'h80, 1'b1};

    Reset = 1'b1;
    din8 = '0; ld8 = 0; ex8 = 0; sg8 = 0;
    din16 = '0; ld16 = 0; ex16 = 0; sg16 = 0;
    #12;
    chk("reset A8", a8, 8'h00);
    chk("reset B8", b8, 8'h00);
    chk("reset X8/Busy8/Done8", {x8, busy8, done8}, 3'b000);
    chk("reset A16/B16", {a16, b16}, 32'h0);
    chk("reset X16/Busy16/Done16", {x16, busy16, done16}, 3'b000);
    tick;
    Reset = 1'b0;
    tick;

    for (int i = 0; i < 10; i++) begin
      start8(vecs[i].b, vecs[i].m, vecs[i].sgn, 1'b0);
      push_exp({8'h00, vecs[i].ea}, {8'h00, vecs[i].eb}, vecs[i].ex);
      finish8(vecs[i].nm, 8);
    end

    for (int i = 0; i < 6; i++) begin
      rb = 8'($urandom); rm = 8'($urandom); rs = 1'($urandom);
      if (rs) prod = int'($signed(rb)) * int'($signed(rm));
      else    prod = int'(rb) * int'(rm);
      p = prod[15:0];
      start8(rb, rm, rs, 1'b0);
      push_exp({8'h00, p[15:8]}, {8'h00, p[7:0]}, rs & p[15]);
      finish8($sformatf("rand%0d %s 0x%02h*0x%02h", i, rs ? "s" : "u", rb, rm), 8);
    end

    // Both controls high in IDLE: load wins, then Execute starts once load drops.
    ld8 = 1'b1; ex8 = 1'b1; din8 = 8'h5A; sg8 = 1'b0;
    tick;
    chk("both high: B loaded", b8, 8'h5A);
    chk("both high: A cleared", a8, 8'h00);
    chk("both high: no start", busy8, 1'b0);
    ld8 = 1'b0; din8 = 8'h02;
    tick;
    chk("execute after load", busy8, 1'b1);
    ex8 = 1'b0;
    push_exp(16'h0000, 16'h00B4, 1'b0);
    finish8("u 0x5A*0x02", 8);

    // ClearA_loadB pulsed during RUN must be ignored.
    start8(8'h05, 8'h03, 1'b0, 1'b0);
    push_exp(16'h0000, 16'h000F, 1'b0);
    tick; tick;
    ld8 = 1'b1; din8 = 8'hAA;
    tick;
    ld8 = 1'b0;
    finish8("load during run", 5);

    // Execute held high through and after completion: no restart.
    start8(8'hFF, 8'hFF, 1'b0, 1'b1);
    push_exp(16'h00FE, 16'h0001, 1'b0);
    finish8("held execute", 8);
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      tick;
      if (busy8 || done8 || a8 != 8'hFE || b8 != 8'h01) bad++;
    end
    chk("held execute: bad cycles", 64'(bad), 64'(0));
    ex8 = 1'b0;
    tick; tick;
    chk("held execute released: idle", busy8, 1'b0);
    chk("held execute released: product kept", {a8, b8}, 16'hFE01);

    // 16-bit: exact Done timing and width.
    ld16 = 1'b1; din16 = 16'h0001;
    tick;
    ld16 = 1'b0; din16 = 16'h8000; sg16 = 1'b1; ex16 = 1'b1;
    tick;
    ex16 = 1'b0;
    push_exp(16'hFFFF, 16'h8000, 1'b1);
    c = 0;
    while (!done16 && c < 40) begin
      tick;
      c++;
    end
    chk("w16 done latency", 64'(c), 64'(16));
    if (exp_q.size() == 0) begin
      chk("w16 scoreboard", 64'(0), 64'(1));
    end else begin
      exp_t e;
      e = exp_q.pop_front();
      chk("w16 A:B", {a16, b16}, {e.a, e.b});
      chk("w16 X", x16, e.x);
    end
    tick;
    chk("w16 done width", done16, 1'b0);

    // Asynchronous reset between edges after step 3.
    start8(8'hFD, 8'h07, 1'b1, 1'b0);
    tick; tick; tick;
    #2;
    Reset = 1'b1;
    #1;
    chk("async reset A/B", {a8, b8}, 16'h0000);
    chk("async reset X/Busy/Done", {x8, busy8, done8}, 3'b000);
    tick;
    #2;
    Reset = 1'b0;
    tick;
    chk("after reset idle", busy8, 1'b0);
    start8(8'hFD, 8'h07, 1'b1, 1'b0);
    push_exp(16'h00FF, 16'h00EB, 1'b1);
    finish8("rerun after reset", 8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
